// File: rtl/seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// seq_detect_scheduler
//   Word-level front end for a serial "10110" sequence detector (Moore or
//   Mealy). A word accepted on the input handshake is serialised MSB-first
//   onto j. The detector is cleared first. The detector's w pulses are
//   counted with saturation, and the count is returned on the output
//   handshake.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   in_valid   in   1      source word valid
//   in_data    in   WIDTH  word to scan, MSB sent first
//   in_ready   out  1      block can accept a word (IDLE only)
//   j          out  1      serial bit to detector
//   det_clr    out  1      one-cycle clear pulse to detector
//   w          in   1      detector match output
//   out_valid  out  1      out_count valid
//   out_count  out  CNT_W  saturating match count for the last word
//   out_ready  in   1      sink accepts out_count
//   busy       out  1      high whenever not IDLE
// -----------------------------------------------------------------------------
module seq_detect_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int DRAIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             j,
    output logic             det_clr,
    input  logic             w,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             busy
);

    // One counter serves both the SHIFT bit index and the DRAIN cycle index.
    localparam int BC_W = $clog2(WIDTH + DRAIN + 1);
    localparam logic [BC_W-1:0]  LAST_BIT   = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]  LAST_DRAIN = BC_W'((DRAIN > 0) ? DRAIN - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             j_q;
    logic             det_clr_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Saturating increment: the count sticks at its maximum instead of wrapping.
    assign count_d = (w && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            count_q     <= '0;
            j_q         <= 1'b0;
            det_clr_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shift_q    <= in_data;
                        count_q    <= '0;
                        det_clr_q  <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // Preload bit 0 so that j is already valid in the first SHIFT cycle.
                    det_clr_q <= 1'b0;
                    j_q       <= shift_q[WIDTH-1];
                    shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_q <= '0;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    count_q <= count_d;
                    if (bit_cnt_q == LAST_BIT) begin
                        j_q         <= 1'b0;
                        bit_cnt_q   <= '0;
                        state_q     <= (DRAIN > 0) ? S_DRAIN : S_DONE;
                        out_valid_q <= (DRAIN == 0);
                    end else begin
                        j_q       <= shift_q[WIDTH-1];
                        shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A Moore detector reports its match for the last bit one cycle late.
                    count_q <= count_d;
                    if (bit_cnt_q == LAST_DRAIN) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign j         = j_q;
    assign det_clr   = det_clr_q;
    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_scheduler
//   Three scheduler instances run side by side:
//     unit 0: Moore detector, DRAIN=1, CNT_W=4
//     unit 1: Mealy detector, DRAIN=0, CNT_W=4
//     unit 2: Mealy detector, DRAIN=0, CNT_W=1 (saturation)
//   Each instance has its own behavioural "10110" detector, and all of them
//   share one clock and one reset. The expected count for a word is the
//   number of overlapping "10110" windows in that word, clipped to the
//   counter maximum.
// -----------------------------------------------------------------------------
module tb_seq_detect_scheduler;

    logic       clk;
    logic       rst;
    logic       iv   [3];
    logic [7:0] id   [3];
    logic       ordy [3];
    logic       ir   [3];
    logic       jw   [3];
    logic       clr  [3];
    logic       w_w  [3];
    logic       ov   [3];
    logic       bz   [3];
    logic [3:0] oc_moore;
    logic [3:0] oc_mealy;
    logic [0:0] oc_sat;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_detect_scheduler #(.WIDTH(8), .CNT_W(4), .DRAIN(1)) u_moore (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
        .j(jw[0]), .det_clr(clr[0]), .w(w_w[0]), .out_valid(ov[0]),
        .out_count(oc_moore), .out_ready(ordy[0]), .busy(bz[0])
    );

    seq_detect_scheduler #(.WIDTH(8), .CNT_W(4), .DRAIN(0)) u_mealy (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
        .j(jw[1]), .det_clr(clr[1]), .w(w_w[1]), .out_valid(ov[1]),
        .out_count(oc_mealy), .out_ready(ordy[1]), .busy(bz[1])
    );

    seq_detect_scheduler #(.WIDTH(8), .CNT_W(1), .DRAIN(0)) u_sat (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id[2]), .in_ready(ir[2]),
        .j(jw[2]), .det_clr(clr[2]), .w(w_w[2]), .out_valid(ov[2]),
        .out_count(oc_sat), .out_ready(ordy[2]), .busy(bz[2])
    );

    // Behavioural detectors: h holds the last four bits seen since the last clear.
    // The Mealy output is the window match on the current bit. The Moore output is
    // that same match registered.
    for (genvar gi = 0; gi < 3; gi++) begin : g_det
        logic [3:0] h;
        logic       m;
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                h <= '0;
                m <= 1'b0;
            end else if (clr[gi]) begin
                h <= '0;
                m <= 1'b0;
            end else begin
                h <= {h[2:0], jw[gi]};
                m <= ({h, jw[gi]} == 5'b10110);
            end
        end
        assign w_w[gi] = (gi == 0) ? m : ({h, jw[gi]} == 5'b10110);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_count(input logic [7:0] d, input int maxc);
        int n = 0;
        for (int p = 0; p < 4; p++) begin
            if (d[7-p -: 5] == 5'b10110) n++;
        end
        if (n > maxc) n = maxc;
        return 4'(n);
    endfunction

    function automatic logic [3:0] get_oc(input int u);
        case (u)
            0:       return oc_moore;
            1:       return oc_mealy;
            default: return {3'b000, oc_sat};
        endcase
    endfunction

    // A full transaction on unit u. hold is the number of DONE cycles with
    // out_ready low; hold=0 means out_ready is already high when DONE is entered.
    task automatic run_word(input int u, input logic [7:0] data, input int hold, input string tag);
        int         c;
        int         clr_n;
        int         lat_exp;
        bit         seen;
        logic [7:0] jseq;
        logic [3:0] exp;
        exp     = exp_count(data, (u == 2) ? 1 : 15);
        lat_exp = (u == 0) ? 10 : 9;
        check({tag, "_in_ready"}, 32'(ir[u]), 32'd1);
        ordy[u] = (hold == 0);
        iv[u]   = 1'b1;
        id[u]   = data;
        @(posedge clk); #1;
        c     = 0;
        clr_n = 0;
        jseq  = '0;
        seen  = 1'b0;
        // Random in_valid/in_data traffic while busy must be ignored.
        while (c < 40 && !seen) begin
            if (ov[u]) begin
                seen = 1'b1;
            end else begin
                if (clr[u]) clr_n++;
                if (c >= 1 && c <= 8) jseq[8-c] = jw[u];
                iv[u] = 1'($urandom);
                id[u] = 8'($urandom);
                @(posedge clk); #1;
                c++;
            end
        end
        iv[u] = 1'b0;
        check({tag, "_latency"}, 32'(c), 32'(lat_exp));
        check({tag, "_jseq"}, 32'(jseq), 32'(data));
        check({tag, "_clr_pulses"}, 32'(clr_n), 32'd1);
        check({tag, "_count"}, 32'(get_oc(u)), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            iv[u] = 1'($urandom);
            id[u] = 8'($urandom);
            @(posedge clk); #1;
            check({tag, "_stall"}, {27'd0, ov[u], ir[u], get_oc(u)}, {27'd0, 1'b1, 1'b0, exp});
        end
        iv[u]   = 1'b0;
        ordy[u] = 1'b1;
        @(posedge clk); #1;
        check({tag, "_release"}, {29'd0, ov[u], ir[u], bz[u]}, {29'd0, 3'b010});
        ordy[u] = 1'b0;
        $display("txn %s unit=%0d data=%b hold=%0d count=%0d latency=%0d", tag, u, data, hold, get_oc(u), c);
    endtask

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            iv[u]   = 1'b0;
            id[u]   = '0;
            ordy[u] = 1'b0;
        end
        #12;
        for (int u = 0; u < 3; u++) begin
            check("reset_state", {26'd0, ir[u], jw[u], clr[u], ov[u], bz[u], 1'b0},
                  {26'd0, 6'b100000});
            check("reset_count", 32'(get_oc(u)), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed words on the Moore and Mealy units
        for (int u = 0; u < 2; u++) begin
            run_word(u, 8'b10110000, 0, "single");
            run_word(u, 8'b10110110, 0, "overlap");
            run_word(u, 8'b00010110, 0, "tail");
            run_word(u, 8'b00000101, 0, "wordA");
            run_word(u, 8'b10000000, 0, "wordB");
            run_word(u, 8'b10110110, 5, "stall5");
        end

        // Asynchronous reset during SHIFT cycle 3 on the Moore unit
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        id[0]   = 8'b10110000;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("midreset_outputs", {28'd0, jw[0], bz[0], ov[0], ir[0]}, {28'd0, 4'b0001});
        @(posedge clk); #1;
        rst = 1'b1;
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        check("midreset_no_valid", {30'd0, ov[0], bz[0]}, 32'd0);
        run_word(0, 8'b10110000, 0, "after_reset");

        // Saturation unit
        run_word(2, 8'b10110110, 0, "saturate");
        run_word(2, 8'b00000000, 1, "sat_zero");

        // Randomised words against the reference model
        for (int n = 0; n < 12; n++) begin
            for (int u = 0; u < 3; u++) begin
                run_word(u, 8'($urandom), int'($urandom_range(0, 3)), "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
